mem_arbiter: RTL and testbench

Shares the CPU's single-port RAM between the instruction-fetch port and the load/store data port. Each cycle it picks one requester and drives the RAM with that request. A depth-`RAM_LATENCY` tag pipeline sends read data back to the port that issued the read. Data accesses have fixed priority, and a counter guarantees fetch cannot be starved. The block sits between the CPU core and the RAM, inside `cpu`.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the core/RAM side.
interface mem_arbiter_if #(
  parameter int CPU_WIDTH = 32,
  parameter int RAM_WIDTH = 31
);
  logic                   i_req;
  logic [CPU_WIDTH-1:0]   i_addr;
  logic                   i_gnt;
  logic                   i_rvalid;
  logic [CPU_WIDTH-1:0]   i_rdata;

  logic                   d_req;
  logic                   d_we;
  logic [CPU_WIDTH/8-1:0] d_be;
  logic [CPU_WIDTH-1:0]   d_addr;
  logic [CPU_WIDTH-1:0]   d_wdata;
  logic                   d_gnt;
  logic                   d_rvalid;
  logic [CPU_WIDTH-1:0]   d_rdata;

  logic                   ram_en;
  logic                   ram_we;
  logic [CPU_WIDTH/8-1:0] ram_be;
  logic [RAM_WIDTH-3:0]   ram_addr;
  logic [CPU_WIDTH-1:0]   ram_wdata;
  logic [CPU_WIDTH-1:0]   ram_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output ram_en, ram_we, ram_be, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  ram_en, ram_we, ram_be, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: fixed data-port priority with a fetch starvation
// guard, and a tag pipeline that routes read data back to the issuing port.
module mem_arbiter #(
  parameter int CPU_WIDTH    = 32,
  parameter int RAM_WIDTH    = 31,
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          a_reset_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                   i_win;
  logic                   d_win;
  logic                   rd_issue;
  logic [3:0]             starve_q;
  logic [3:0]             starve_d;
  logic [RAM_LATENCY-1:0] tag_vld_q;
  logic [RAM_LATENCY-1:0] tag_vld_d;
  logic [RAM_LATENCY-1:0] tag_dat_q;
  logic [RAM_LATENCY-1:0] tag_dat_d;
  logic                   unused_addr_bits;

  // Data wins a tie unless fetch has already lost STARVE_LIMIT times in a row.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (a_reset_n) begin
      if (bus.d_req && !(bus.i_req && (starve_q == LIMIT))) begin
        d_win = 1'b1;
      end else if (bus.i_req) begin
        i_win = 1'b1;
      end
    end
  end

  assign bus.i_gnt     = i_win;
  assign bus.d_gnt     = d_win;
  assign bus.ram_en    = i_win | d_win;
  assign bus.ram_we    = d_win & bus.d_we;
  assign bus.ram_be    = d_win ? bus.d_be : '1;
  assign bus.ram_addr  = d_win ? bus.d_addr[RAM_WIDTH-1:2] : bus.i_addr[RAM_WIDTH-1:2];
  assign bus.ram_wdata = bus.d_wdata;

  assign rd_issue = bus.ram_en & ~bus.ram_we;

  always_comb begin
    starve_d = 4'd0;
    if (bus.i_req && !i_win) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    end
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_dat_d    = '0;
    tag_vld_d[0] = rd_issue;
    tag_dat_d[0] = d_win;
    for (int s = 1; s < RAM_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_dat_d[s] = tag_dat_q[s-1];
    end
  end

  // Control state clears on reset; the is_data tag bits are only qualified by valid.
  always_ff @(posedge clk) begin
    if (!a_reset_n) begin
      starve_q  <= 4'd0;
      tag_vld_q <= '0;
    end else begin
      starve_q  <= starve_d;
      tag_vld_q <= tag_vld_d;
    end
    tag_dat_q <= tag_dat_d;
  end

  assign bus.i_rvalid = a_reset_n & tag_vld_q[RAM_LATENCY-1] & ~tag_dat_q[RAM_LATENCY-1];
  assign bus.d_rvalid = a_reset_n & tag_vld_q[RAM_LATENCY-1] &  tag_dat_q[RAM_LATENCY-1];
  assign bus.i_rdata  = bus.ram_rdata;
  assign bus.d_rdata  = bus.ram_rdata;

  // Low address bits and bits above the decoded RAM window are ignored.
  assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0],
                              bus.i_addr[CPU_WIDTH-1:RAM_WIDTH],
                              bus.d_addr[CPU_WIDTH-1:RAM_WIDTH]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (latency 1, 2, 3) share one stimulus
// stream and are checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int CW = 32;
  localparam int RW = 31;
  localparam int SL = 4;
  localparam int NL = 3;
  localparam int MW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tb_i_req;
  logic [31:0] tb_i_addr;
  logic        tb_d_req;
  logic        tb_d_we;
  logic [3:0]  tb_d_be;
  logic [31:0] tb_d_addr;
  logic [31:0] tb_d_wdata;

  logic        lane_igt  [NL];
  logic        lane_dgt  [NL];
  logic        lane_ren  [NL];
  logic        lane_rwe  [NL];
  logic [3:0]  lane_rbe  [NL];
  logic [28:0] lane_raddr[NL];
  logic [31:0] lane_rwd  [NL];
  logic        lane_iv   [NL];
  logic        lane_dv   [NL];
  logic [31:0] lane_ird  [NL];
  logic [31:0] lane_drd  [NL];

  function automatic logic [31:0] init_word(input int w);
    if (w == 4) return 32'hDEADBEEF;
    if (w == 2) return 32'h12345678;
    return 32'hC0DE0000 | 32'(w);
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int LAT = g + 1;

    mem_arbiter_if #(.CPU_WIDTH(CW), .RAM_WIDTH(RW)) bus ();

    mem_arbiter #(
      .CPU_WIDTH(CW), .RAM_WIDTH(RW), .RAM_LATENCY(LAT), .STARVE_LIMIT(SL)
    ) dut (
      .clk(clk),
      .a_reset_n(rst_n),
      .bus(bus)
    );

    logic [31:0] ram   [MW];
    logic [31:0] rpipe [LAT];

    always @(posedge clk) begin
      if (!rst_n) begin
        for (int w = 0; w < MW; w++) ram[w] <= init_word(w);
      end else if (bus.ram_en && bus.ram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be[b]) ram[bus.ram_addr[5:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
      rpipe[0] <= (bus.ram_en && !bus.ram_we) ? ram[bus.ram_addr[5:0]] : 32'hBAD00000;
      for (int s = 1; s < LAT; s++) rpipe[s] <= rpipe[s-1];
    end

    assign bus.ram_rdata = rpipe[LAT-1];
    assign bus.i_req     = tb_i_req;
    assign bus.i_addr    = tb_i_addr;
    assign bus.d_req     = tb_d_req;
    assign bus.d_we      = tb_d_we;
    assign bus.d_be      = tb_d_be;
    assign bus.d_addr    = tb_d_addr;
    assign bus.d_wdata   = tb_d_wdata;

    assign lane_igt[g]   = bus.i_gnt;
    assign lane_dgt[g]   = bus.d_gnt;
    assign lane_ren[g]   = bus.ram_en;
    assign lane_rwe[g]   = bus.ram_we;
    assign lane_rbe[g]   = bus.ram_be;
    assign lane_raddr[g] = bus.ram_addr;
    assign lane_rwd[g]   = bus.ram_wdata;
    assign lane_iv[g]    = bus.i_rvalid;
    assign lane_dv[g]    = bus.d_rvalid;
    assign lane_ird[g]   = bus.i_rdata;
    assign lane_drd[g]   = bus.d_rdata;
  end

  // Model state: expected responses live in an 8-slot ring indexed by cycle.
  int          checks;
  int          errors;
  int          cnum;
  int          model_wait;
  logic        model_last_i;
  logic [31:0] mmem    [MW];
  bit          ring_iv [NL][8];
  bit          ring_dv [NL][8];
  logic [31:0] ring_rd [NL][8];

  task automatic chk(input int lane, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d cycle%0d actual=%h required=%h", nm, lane, cnum, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic        e_i, e_d, e_rd, ev;
    logic [31:0] w_addr;
    int          slot;
    e_i = 1'b0;
    e_d = 1'b0;
    if (rst_n) begin
      e_i = tb_i_req && (!tb_d_req || model_wait == SL);
      e_d = tb_d_req && !e_i;
    end
    w_addr = e_d ? tb_d_addr : tb_i_addr;
    e_rd   = e_i || (e_d && !tb_d_we);
    slot   = cnum % 8;
    for (int l = 0; l < NL; l++) begin
      chk(l, "i_gnt", 32'(lane_igt[l]), 32'(e_i));
      chk(l, "d_gnt", 32'(lane_dgt[l]), 32'(e_d));
      chk(l, "ram_en", 32'(lane_ren[l]), 32'(e_i | e_d));
      if (!rst_n || e_i || e_d)
        chk(l, "ram_we", 32'(lane_rwe[l]), 32'(e_d && tb_d_we));
      if (e_i || e_d) begin
        chk(l, "ram_addr", 32'(lane_raddr[l]), 32'(w_addr[30:2]));
        chk(l, "ram_be", 32'(lane_rbe[l]), e_d ? 32'(tb_d_be) : 32'hF);
        if (e_d && tb_d_we) chk(l, "ram_wdata", lane_rwd[l], tb_d_wdata);
      end
      ev = ring_iv[l][slot] && rst_n;
      chk(l, "i_rvalid", 32'(lane_iv[l]), 32'(ev));
      if (ev) chk(l, "i_rdata", lane_ird[l], ring_rd[l][slot]);
      ev = ring_dv[l][slot] && rst_n;
      chk(l, "d_rvalid", 32'(lane_dv[l]), 32'(ev));
      if (ev) chk(l, "d_rdata", lane_drd[l], ring_rd[l][slot]);
      ring_iv[l][slot] = 1'b0;
      ring_dv[l][slot] = 1'b0;
    end
    model_last_i = e_i;
    if (!rst_n) begin
      for (int l = 0; l < NL; l++)
        for (int s = 0; s < 8; s++) begin
          ring_iv[l][s] = 1'b0;
          ring_dv[l][s] = 1'b0;
        end
      for (int w = 0; w < MW; w++) mmem[w] = init_word(w);
      model_wait = 0;
    end else begin
      if (e_rd)
        for (int l = 0; l < NL; l++) begin
          ring_iv[l][(cnum + l + 1) % 8] = e_i;
          ring_dv[l][(cnum + l + 1) % 8] = e_d;
          ring_rd[l][(cnum + l + 1) % 8] = mmem[w_addr[7:2]];
        end
      if (e_d && tb_d_we)
        for (int b = 0; b < 4; b++)
          if (tb_d_be[b]) mmem[w_addr[7:2]][8*b +: 8] = tb_d_wdata[8*b +: 8];
      model_wait = (tb_i_req && !e_i) ? ((model_wait < SL) ? model_wait + 1 : SL) : 0;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    check_cycle();
    @(posedge clk);
    #1;
    cnum++;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      at_neg();
      finish_cycle();
    end
  endtask

  task automatic idle();
    tb_i_req = 1'b0;
    tb_d_req = 1'b0;
    tb_d_we  = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] a);
    tb_d_req  = 1'b1;
    tb_d_we   = 1'b0;
    tb_d_be   = 4'hF;
    tb_d_addr = a;
  endtask

  logic [9:0] seq_dut, seq_model;
  logic [8:0] iv_seq, dv_seq;

  initial begin
    checks = 0; errors = 0; cnum = 0; model_wait = 0; model_last_i = 1'b0;
    for (int l = 0; l < NL; l++)
      for (int s = 0; s < 8; s++) begin
        ring_iv[l][s] = 1'b0;
        ring_dv[l][s] = 1'b0;
        ring_rd[l][s] = '0;
      end
    rst_n = 1'b0;
    tb_i_req = 1'b1; tb_i_addr = 32'h10;
    tb_d_req = 1'b1; tb_d_we = 1'b1; tb_d_be = 4'hF; tb_d_addr = 32'h8; tb_d_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    cyc(3);
    rst_n = 1'b1;
    idle();
    cyc(1);

    // Single fetch from word 4
    tb_i_req = 1'b1; tb_i_addr = 32'h10;
    at_neg();
    chk(0, "sf_gnt", 32'(lane_igt[0]), 32'h1);
    chk(0, "sf_addr", 32'(lane_raddr[0]), 32'h4);
    chk(0, "sf_we", 32'(lane_rwe[0]), 32'h0);
    finish_cycle();
    idle();
    at_neg();
    chk(0, "sf_rvalid", 32'(lane_iv[0]), 32'h1);
    chk(0, "sf_rdata", lane_ird[0], 32'hDEADBEEF);
    chk(0, "sf_no_drvalid", 32'(lane_dv[0]), 32'h0);
    finish_cycle();
    cyc(3);

    // Partial store over word 2, then load it back
    tb_d_req = 1'b1; tb_d_we = 1'b1; tb_d_be = 4'b0011; tb_d_addr = 32'h8; tb_d_wdata = 32'h0000ABCD;
    cyc(1);
    set_load(32'h8);
    at_neg();
    chk(0, "store_no_rvalid", 32'(lane_dv[0]), 32'h0);
    finish_cycle();
    idle();
    at_neg();
    chk(0, "load_rvalid", 32'(lane_dv[0]), 32'h1);
    chk(0, "load_rdata", lane_drd[0], 32'h1234ABCD);
    finish_cycle();
    cyc(3);

    // Both ports held for 10 cycles
    tb_i_req = 1'b1; tb_i_addr = 32'h20;
    set_load(32'h4);
    for (int k = 0; k < 10; k++) begin
      at_neg();
      seq_dut = {seq_dut[8:0], lane_igt[0]};
      finish_cycle();
      seq_model = {seq_model[8:0], model_last_i};
    end
    chk(0, "starve_seq_dut", 32'(seq_dut), 32'h021);
    chk(0, "starve_seq_model", 32'(seq_model), 32'h021);
    idle();
    cyc(4);

    // Alternating fetch/load grants, watched on the latency-3 instance
    iv_seq = '0;
    dv_seq = '0;
    for (int k = 0; k < 9; k++) begin
      idle();
      if (k < 6) begin
        if (k % 2 == 0) begin
          tb_i_req = 1'b1; tb_i_addr = 32'(4 * k);
        end else begin
          set_load(32'(4 * k + 32'h40));
        end
      end
      at_neg();
      iv_seq = {iv_seq[7:0], lane_iv[2]};
      dv_seq = {dv_seq[7:0], lane_dv[2]};
      finish_cycle();
    end
    chk(2, "order_iv", 32'(iv_seq), 32'h02A);
    chk(2, "order_dv", 32'(dv_seq), 32'h015);
    idle();
    cyc(2);

    // Reset one cycle after a load grant drops the response
    set_load(32'h8);
    cyc(1);
    idle();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    tb_i_req = 1'b1; tb_i_addr = 32'h10;
    at_neg();
    chk(1, "rst_no_drvalid", 32'(lane_dv[1]), 32'h0);
    chk(1, "rst_release_gnt", 32'(lane_igt[1]), 32'h1);
    finish_cycle();
    idle();
    at_neg();
    chk(1, "rst_no_drvalid2", 32'(lane_dv[1]), 32'h0);
    chk(1, "rst_fetch_rvalid", 32'(lane_iv[0]), 32'h1);
    finish_cycle();
    cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
